des_stream_mux: RTL
===================

Name: des_stream_mux

Overview:
- Parametrised, registered N-to-1 block selector for the DES datapath. It replaces the fixed 2:1 combinational 64-bit selector.
- It arbitrates among NUM_CH valid/ready input channels of WIDTH-bit blocks, for example plaintext feed vs. round feedback or multiple requesters.
- It forwards one block per transfer into a registered output stage and tags each block with its source channel.
- Selection mode is fixed priority or round-robin, chosen at run time.

Parameters:
- WIDTH, 64, data block width in bits.
- NUM_CH, 2, number of input channels (2..16).
- CH_W, 4, width of the channel index; must satisfy 2^CH_W >= NUM_CH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- rr_en  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- flush  input  1  synchronous clear of the output stage.
- in_valid  input  NUM_CH  per-channel valid; bit k belongs to channel k.
- in_data  input  NUM_CH*WIDTH  packed blocks, [0:NUM_CH*WIDTH-1]; channel k occupies bits k*WIDTH to k*WIDTH+WIDTH-1.
- in_ready  output  NUM_CH  per-channel ready.
- out_valid  output  1  output block valid.
- out_data  output  WIDTH  output block, [0:WIDTH-1], bit 0 = DES bit 1 (MSB).
- out_ch  output  CH_W  source channel of out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset is asynchronous on rst high. out_valid=0, out_data=0, out_ch=0, RR pointer last=NUM_CH-1 so that channel 0 has top priority first. in_ready is combinational and follows from the reset state.
- Output stage has one entry. It can load when empty or when draining, i.e. load_ok = ~out_valid | out_ready.
- Grant is combinational, one-hot or zero, computed from in_valid:
  - rr_en=0: the lowest set index wins.
  - rr_en=1: search starts at last+1 and wraps modulo NUM_CH. The first set bit wins.
- in_ready[k] = grant[k] & load_ok & ~flush. At most one in_ready bit is high.
- in_ready must not depend on in_data. It depends on in_valid only through the grant.
- A transfer on channel k (in_valid[k] & in_ready[k]) loads on the next edge: out_data = block k, out_ch = k, out_valid = 1. In round-robin mode last is also set to k.
- last updates only on a transfer. When rr_en=0, last still tracks the most recent grant, so switching to RR mode continues fairly.
- Output drain: out_valid & out_ready with no new transfer sets out_valid=0 on the next edge. out_data and out_ch hold their values.
- Simultaneous drain and load: out_valid stays 1 and the new block replaces the old one. This gives zero-bubble throughput of 1 block per cycle.
- Stall: while out_valid & ~out_ready, out_data and out_ch must not change and no in_ready is asserted.
- Latency is 1 cycle from input transfer to out_valid.
- flush (synchronous): out_valid=0 on the next edge and no transfer is accepted that cycle. out_data and out_ch hold; last is unchanged. flush takes priority over both load and drain.
- Changing rr_en affects the grant in the same cycle. Mid-stream changes are legal.
- An input channel may drop in_valid before it is granted. No state is held per input.
- Reset asserted mid-transfer: the pending output block is discarded and the state returns to reset values immediately.
- NUM_CH=1 degenerates to a registered pipeline stage. grant[0] = in_valid[0] and out_ch = 0.

Test Plan:
1. Reset, then on ch0 and ch1 (NUM_CH=2) drive in_valid=2'b11 with ch0=64'h0123456789ABCDEF and ch1=64'hFEDCBA9876543210, rr_en=0, out_ready=1 -> in_ready=2'b01 every cycle. out_data=64'h0123456789ABCDEF and out_ch=0 from cycle 1 onward; ch1 is starved.
2. Same stimulus with rr_en=1 -> grants alternate 0,1,0,1. out_ch sequence is 0,1,0,1 and out_valid stays continuously high.
3. out_ready=0 for 5 cycles after the first load -> out_data and out_ch are stable and in_ready=0 throughout. On release, the next block appears 1 cycle later with no lost or duplicated blocks (scoreboard check).
4. NUM_CH=4, rr_en=1, last=2, in_valid=4'b0011 -> channel 0 is granted (wrap). A subsequent grant with in_valid=4'b0011 goes to channel 1.
5. flush pulsed while out_valid=1 and in_valid=1 -> out_valid=0 the next cycle, in_ready=0 during the flush cycle, and no block is accepted.
6. rst asserted asynchronously between edges while out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately. After release, the first RR grant goes to ch0.

Source files
------------

// File: rtl/des_stream_mux.sv
// NUM_CH-to-1 block selector, fixed-priority or round-robin, tagging each block with its source channel.
// One-cycle latency into a single registered output entry; in_ready is withheld while that entry is stalled or flushed.
module des_stream_mux #(
  parameter int WIDTH  = 64,
  parameter int NUM_CH = 2,
  parameter int CH_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rr_en,
  input  logic                      flush,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [0:NUM_CH*WIDTH-1]   in_data,
  output logic [NUM_CH-1:0]         in_ready,
  output logic                      out_valid,
  output logic [0:WIDTH-1]          out_data,
  output logic [CH_W-1:0]           out_ch,
  input  logic                      out_ready
);

  logic [CH_W-1:0]   last;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   sel;
  logic [0:WIDTH-1]  sel_data;
  logic              load_ok;
  logic              xfer;
  logic              hit;
  int                pos;

  // Walk channels in priority order; in round-robin the order starts just after the last winner.
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    pos   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      pos = rr_en ? (int'(last) + 1 + i) % NUM_CH : i;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!hit && (j == pos) && in_valid[j]) begin
          grant[j] = 1'b1;
          hit      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel      = '0;
    sel_data = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (grant[j]) begin
        sel      = CH_W'(j);
        sel_data = in_data[j*WIDTH +: WIDTH];
      end
    end
  end

  assign load_ok  = ~out_valid | out_ready;
  assign in_ready = grant & {NUM_CH{load_ok & ~flush}};
  assign xfer     = |(in_valid & in_ready);

  // last tracks every transfer, even in fixed-priority mode, so a switch to round-robin stays fair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= CH_W'(NUM_CH - 1);
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= sel;
      last      <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
